// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage elastic register chain with per-stage flush.
// Empty or flushed stages let upstream elements advance even while the
// output is stalled, so bubbles collapse toward the output end.
module pipe_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [DEPTH-1:0]             flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];

  logic [DEPTH-1:0] free_c;
  logic [DEPTH-1:0] ready_c;
  logic [DEPTH-1:0] up_live_c;
  logic [CW-1:0]    count_c;

  // A stage is free when empty or when its element is being killed.
  always_comb begin
    free_c = ~v_q | flush;
  end

  // Readiness ripples from the output end toward the input end.
  always_comb begin : ready_chain
    logic chain;
    chain   = out_ready;
    ready_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      chain                  = free_c[DEPTH-1-i] | chain;
      ready_c[DEPTH-1-i]     = chain;
    end
  end

  // Live flag offered to each stage by its upstream neighbour.
  always_comb begin
    up_live_c    = '0;
    up_live_c[0] = in_valid;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      up_live_c[i] = v_q[i-1] & ~flush[i-1];
    end
  end

  // Next-state valid and data: load from upstream when ready, else hold.
  always_comb begin
    v_d = (ready_c & up_live_c) | (~ready_c & v_q);
    d_d[0] = (ready_c[0] && up_live_c[0]) ? in_data : d_q[0];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      d_d[i] = (ready_c[i] && up_live_c[i]) ? d_q[i-1] : d_q[i];
    end
  end

  // Occupancy is the population count of the registered valid bits.
  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_c = count_c + CW'(v_q[i]);
    end
  end

  // Stage registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign in_ready    = ready_c[0] & ~reset;
  assign out_valid   = v_q[DEPTH-1] & ~flush[DEPTH-1];
  assign out_data    = d_q[DEPTH-1];
  assign stage_valid = v_q;
  assign count       = count_c;

endmodule

// File: tb/tb_pipe_chain.sv
// Testbench for pipe_chain (DEPTH=4, WIDTH=32): scenario tasks plus a
// scoreboard queue filled on input transfers and drained on output transfers.
module tb_pipe_chain;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  stage_valid;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  pipe_chain #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stage_valid(stage_valid), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: transfers are evaluated mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got %h expected nothing", out_data);
        end else begin
          logic [31:0] exp_v;
          exp_v = sb.pop_front();
          if (out_data !== exp_v) begin
            errors++;
            $display("FAIL sb_order: got %h expected %h", out_data, exp_v);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_remove(input logic [31:0] val);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i] == val) begin
        sb.delete(i);
        break;
      end
    end
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    flush     = '0;
    for (int i = 0; i < 20 && (sb.size() != 0 || count != 0); i++) step();
    checks++;
    if (sb.size() != 0 || count != 0) begin
      errors++;
      $display("FAIL drain_timeout: got sb=%0d count=%0d expected 0 0", sb.size(), count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; flush = '1; out_ready = 1'b1;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_hi: got %b expected 0", in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count_hi: got %0d expected 0", count); end
    reset = 1'b0; in_valid = 1'b0; flush = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    checks++; if (stage_valid !== 4'h0) begin errors++; $display("FAIL rst_stage_valid: got %b expected 0000", stage_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_lo: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; flush = '0;
    in_valid = 1'b1; in_data = 32'd1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      if (cyc < 11) in_data = 32'(cyc + 2);
      else          in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== (cyc >= 3)) begin errors++; $display("FAIL stream_valid c%0d: got %b expected %b", cyc, out_valid, cyc >= 3); end
      if (cyc >= 3) begin
        checks++; if (out_data !== 32'(cyc - 2)) begin errors++; $display("FAIL stream_data c%0d: got %h expected %h", cyc, out_data, cyc - 2); end
      end
      if (cyc < 11) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c%0d: got %b expected 1", cyc, in_ready); end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n_acc;
    n_acc = 0;
    out_ready = 1'b0; flush = '0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 32'hA + 32'(i);
      #1;
      if (!in_ready) break;
      n_acc++;
      step();
    end
    checks++; if (n_acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", n_acc); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", count); end
    checks++; if (stage_valid !== 4'hF) begin errors++; $display("FAIL bp_stage_valid: got %b expected 1111", stage_valid); end
    checks++; if (in_data !== 32'hE || in_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked: got data=%h rdy=%b expected e 0", in_data, in_ready); end
    step(); step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_hold_count: got %0d expected 4", count); end
    checks++; if (out_data !== 32'hA) begin errors++; $display("FAIL bp_head: got %h expected a", out_data); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_freed_ready: got %b expected 1", in_ready); end
    step();
    in_data = 32'hF;
    #1;
    checks++; if (out_data !== 32'hB) begin errors++; $display("FAIL bp_next_head: got %h expected b", out_data); end
    step();
    drain();
  endtask

  task automatic test_flush();
    fill(32'h10, 4);
    checks++; if (stage_valid !== 4'hF) begin errors++; $display("FAIL fl_full: got %b expected 1111", stage_valid); end
    flush = 4'b0110;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fl_out_valid: got %b expected 1", out_valid); end
    sb_remove(32'h11);
    sb_remove(32'h12);
    step();
    flush = '0;
    #1;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL fl_count: got %0d expected 2", count); end
    checks++; if (stage_valid !== 4'b1010) begin errors++; $display("FAIL fl_stage_valid: got %b expected 1010", stage_valid); end
    checks++; if (out_data !== 32'h10) begin errors++; $display("FAIL fl_head: got %h expected 10", out_data); end
    drain();
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0; flush = '0;
    in_valid = 1'b1; in_data = 32'h55; step();
    in_data = 32'h66; step();
    in_valid = 1'b0; step(); step();
    checks++; if (stage_valid !== 4'b1100 || out_data !== 32'h55) begin errors++; $display("FAIL sim_setup: got %b/%h expected 1100/55", stage_valid, out_data); end
    out_ready = 1'b1; flush = 4'b1000;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sim_out_valid: got %b expected 0", out_valid); end
    sb_remove(32'h55);
    step();
    flush = '0;
    #1;
    checks++; if (stage_valid !== 4'b1000) begin errors++; $display("FAIL sim_stage_valid: got %b expected 1000", stage_valid); end
    checks++; if (out_data !== 32'h66 || out_valid !== 1'b1) begin errors++; $display("FAIL sim_advance: got %h/%b expected 66/1", out_data, out_valid); end
    drain();
  endtask

  task automatic test_reset_midstream();
    fill(32'h21, 3);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mr_count_pre: got %0d expected 3", count); end
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h99;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mr_in_ready_hi: got %b expected 0", in_ready); end
    step();
    reset = 1'b0; in_valid = 1'b0;
    sb.delete();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mr_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid: got %b expected 0", out_valid); end
    checks++; if (stage_valid !== 4'h0) begin errors++; $display("FAIL mr_stage_valid: got %b expected 0000", stage_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready_lo: got %b expected 1", in_ready); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mr_no_capture: got %0d expected 0", count); end
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0; flush = '0;
    in_valid = 1'b1; in_data = 32'h31; step();
    in_valid = 1'b0; step(); step(); step();
    in_valid = 1'b1; in_data = 32'h32; step();
    in_data = 32'h33;
    #1;
    checks++; if (stage_valid !== 4'b1001) begin errors++; $display("FAIL bc_setup: got %b expected 1001", stage_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bc_in_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (stage_valid !== 4'b1011) begin errors++; $display("FAIL bc_stage_valid: got %b expected 1011", stage_valid); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL bc_count: got %0d expected 3", count); end
    checks++; if (out_data !== 32'h31) begin errors++; $display("FAIL bc_head: got %h expected 31", out_data); end
    drain();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = '0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_reset_midstream();
    test_bubble_collapse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
